// File: rtl/cmp_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// Holds the FSM state encoding, the per-slice result code and the index-width helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_GT   = 2'd1,
        RES_LT   = 2'd2,
        RES_EQ   = 2'd3
    } res_t;

    // A single-slice scan still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational CHUNK-bit unsigned magnitude slice.
// Exactly one of gt_o/lt_o/eq_o is high for any input pair.
module comparator_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o,
    output logic             eq_o
);

    assign gt_o = (a_i >  b_i);
    assign lt_o = (a_i <  b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle magnitude comparator: scans latched operands MSB slice first,
// one CHUNK-bit slice per clock, stopping at the first differing slice.
module comparator_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             less,
    output logic             equal
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = idx_width(NCHUNK);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("comparator_seq: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] a_d, b_d;
    logic [IW-1:0]    idx_q;
    logic             gt_q, lt_q, eq_q;

    logic [CHUNK-1:0] a_slices [NCHUNK];
    logic [CHUNK-1:0] b_slices [NCHUNK];
    logic [CHUNK-1:0] a_sel, b_sel;
    logic             c_gt, c_lt, c_eq;
    res_t             res;

    // Flipping the sign bit maps two's complement onto offset binary,
    // so the scan itself is always unsigned.
    assign a_d = is_signed ? (a ^ MSB_MASK) : a;
    assign b_d = is_signed ? (b ^ MSB_MASK) : b;

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_slices[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_slices[gi] = b_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign a_sel = a_slices[idx_q];
    assign b_sel = b_slices[idx_q];

    comparator_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i  (a_sel),
        .b_i  (b_sel),
        .gt_o (c_gt),
        .lt_o (c_lt),
        .eq_o (c_eq)
    );

    always_comb begin
        res = RES_NONE;
        if (c_gt)      res = RES_GT;
        else if (c_lt) res = RES_LT;
        else if (c_eq) res = RES_EQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        idx_q   <= IW'(NCHUNK - 1);
                        gt_q    <= 1'b0;
                        lt_q    <= 1'b0;
                        eq_q    <= 1'b0;
                        state_q <= COMPARE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                COMPARE: begin
                    case (res)
                        RES_GT: begin
                            gt_q    <= 1'b1;
                            state_q <= DONE;
                        end
                        RES_LT: begin
                            lt_q    <= 1'b1;
                            state_q <= DONE;
                        end
                        RES_EQ: begin
                            if (idx_q == '0) begin
                                eq_q    <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                idx_q <= idx_q - 1'b1;
                            end
                        end
                        default: state_q <= COMPARE;
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q == COMPARE);
    assign done    = (state_q == DONE);
    assign greater = gt_q;
    assign less    = lt_q;
    assign equal   = eq_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq: table of compare vectors plus hand-written
// sequences for reset, flush and start/done handshake corners.
module tb_comparator_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        is_signed = 1'b0;
    logic        busy, done, greater, less, equal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    comparator_seq #(.WIDTH(32), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .greater   (greater),
        .less      (less),
        .equal     (equal)
    );

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic        sgn;
        logic [2:0]  exp_flags;   // {greater, less, equal}
        int          exp_lat;     // cycle (after accept) in which done is high
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a start request just after an edge; returns after the accept edge (+1).
    task automatic accept(input logic [31:0] va, input logic [31:0] vb, input logic sgn);
        a = va;
        b = vb;
        is_signed = sgn;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count cycles until done; lat0 is the cycle number of the current sample.
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt,
                             output int flag_err);
        lat = lat0;
        busy_cnt = 0;
        flag_err = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (busy) busy_cnt++;
            if (busy && (greater || less || equal)) flag_err = 1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic expect_quiet(input string name, input int ncyc);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        check(name, seen, 0);
    endtask

    initial begin
        int lat, bc, ferr;

        vecs[0] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 3'b100, 2};
        vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 3'b010, 2};
        vecs[2] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 3'b001, 9};
        vecs[3] = '{32'hFFFF_FFF5, 32'hFFFF_FFF6, 1'b0, 3'b010, 9};
        vecs[4] = '{32'hFFFF_FFF5, 32'hFFFF_FFF6, 1'b1, 3'b010, 9};
        vecs[5] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 3'b100, 9};
        vecs[6] = '{32'h00F0_0000, 32'h00E0_0000, 1'b0, 3'b100, 4};
        vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3'b010, 2};
        vecs[8] = '{32'h7000_0000, 32'h6FFF_FFFF, 1'b1, 3'b100, 2};

        // Reset state
        #12;
        check("reset_outputs", {busy, done, greater, less, equal}, 0);
        $display("reset held: busy=%0b done=%0b flags=%0b%0b%0b", busy, done, greater, less, equal);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            accept(vecs[i].va, vecs[i].vb, vecs[i].sgn);
            wait_done(1, lat, bc, ferr);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_busy_cycles", i), bc, vecs[i].exp_lat - 1);
            check($sformatf("v%0d_flags", i), {greater, less, equal}, vecs[i].exp_flags);
            check($sformatf("v%0d_flags_zero_busy", i), ferr, 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_idle_hold", i), {busy, done, greater, less, equal},
                  {2'b00, vecs[i].exp_flags});
            $display("vec %0d: a=%h b=%h signed=%0b -> gle=%0b%0b%0b lat=%0d",
                     i, vecs[i].va, vecs[i].vb, vecs[i].sgn, greater, less, equal, lat);
        end

        // Asynchronous reset in the 3rd compare cycle
        accept(32'h1, 32'h1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {busy, done, greater, less, equal}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_quiet("rst_mid_no_done", 12);
        $display("reset mid-op: outputs cleared, no done after release");

        // Start while busy is ignored
        accept(32'h5, 32'h3, 1'b0);
        @(posedge clk); #1;
        a = 32'h1;
        b = 32'h9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3, lat, bc, ferr);
        check("busy_start_latency", lat, 9);
        check("busy_start_flags", {greater, less, equal}, 3'b100);
        $display("start while busy: gle=%0b%0b%0b lat=%0d", greater, less, equal, lat);

        // Start on the done cycle (back-to-back)
        accept(32'h5, 32'h3, 1'b0);
        wait_done(1, lat, bc, ferr);
        check("b2b_first_flags", {done, greater, less, equal}, 4'b1100);
        a = 32'h1;
        b = 32'h9;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_accept_state", {busy, done, greater, less, equal}, 5'b10000);
        wait_done(1, lat, bc, ferr);
        check("b2b_second_latency", lat, 9);
        check("b2b_second_flags", {greater, less, equal}, 3'b010);
        $display("start on done: second op gle=%0b%0b%0b lat=%0d", greater, less, equal, lat);

        // Flush with start in the 4th compare cycle
        @(posedge clk); #1;
        accept(32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        start = 1'b1;
        a = 32'h9;
        b = 32'h1;
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        check("flush_outputs", {busy, done, greater, less, equal}, 0);
        expect_quiet("flush_no_done", 12);
        accept(32'h9, 32'h1, 1'b0);
        wait_done(1, lat, bc, ferr);
        check("post_flush_latency", lat, 9);
        check("post_flush_flags", {greater, less, equal}, 3'b100);
        $display("flush: cleared, following op gle=%0b%0b%0b lat=%0d", greater, less, equal, lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
Parametrised, multi-cycle magnitude comparator; successor to the fixed 4-bit combinational comparator. It scans two WIDTH-bit operands from the most significant CHUNK-bit slice downward, one slice per clock. It terminates early at the first differing slice and supports signed or unsigned mode per operation. It sits beside the execute stage and serves compare/branch-condition micro-ops through a start/done handshake.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 4, bits examined per compare cycle; NCHUNK = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a compare; accepted only when busy==0
flush  input  1  synchronous abort; priority over start
a  input  WIDTH  operand A, sampled on the start-accept edge
b  input  WIDTH  operand B, sampled on the start-accept edge
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with a/b
busy  output  1  high while in COMPARE
done  output  1  one-cycle pulse; result flags are valid from this cycle
greater  output  1  A > B
less  output  1  A < B
equal  output  1  A == B

Behaviour:
- Reset: clk and rst_n are the only clocking signals. Reset is asynchronous and active-low. Asserting rst_n=0 forces state=IDLE and busy=done=greater=less=equal=0, including mid-operation. No done pulse follows a reset.
- States: IDLE, COMPARE, DONE. busy = (state==COMPARE); done = (state==DONE).
- Start accept: happens when start=1, flush=0 and state is IDLE or DONE. On that edge:
  - latch a, b into internal registers; if is_signed=1, invert bit WIDTH-1 of both (offset-binary, so the compare is unsigned from then on);
  - idx <= NCHUNK-1;
  - clear greater/less/equal to 0;
  - go to COMPARE.
- start during COMPARE: ignored; the operand registers do not change.
- COMPARE cycle: compare slice idx of both latched operands (bits idx*CHUNK+CHUNK-1 : idx*CHUNK).
  - slice A > slice B: greater<=1, go to DONE.
  - slice A < slice B: less<=1, go to DONE.
  - slices equal and idx==0: equal<=1, go to DONE.
  - slices equal and idx>0: idx<=idx-1, stay in COMPARE.
- Latency: with the start accepted at edge T, the first compare cycle is T..T+1. done is high during cycle k+1 after T, where k = number of slices examined (1..NCHUNK).
  - Minimum: done in the 2nd cycle after accept.
  - Maximum: done in cycle NCHUNK+1 after accept.
- DONE: lasts one cycle, then goes to IDLE unless a new start is accepted. Back-to-back operations are allowed, giving a gap of zero idle cycles.
- Flags: exactly one of greater/less/equal is 1 from done onward. They hold until the next start accept or flush. They are all 0 while busy.
- flush=1: state<=IDLE, flags<=0, no done pulse, on any state. If start=1 in the same cycle it is dropped.
- WIDTH==CHUNK is legal: always a single compare cycle.
- WIDTH not a multiple of CHUNK: elaboration error.

Decomposition:
- Shared package cmp_pkg holds:
  - state enum (IDLE, COMPARE, DONE);
  - a 2-bit result code (GT, LT, EQ, NONE) for internal use;
  - a function computing the index width clog2(NCHUNK) with a minimum of 1.
- One sub-module: comparator_chunk, a combinational CHUNK-bit gt/lt/eq slice instantiated once on the muxed slice.

Test Plan:
- Reset mid-op: start a=0x0000_0001, b=0x0000_0001, unsigned; pull rst_n low at the 3rd compare cycle (asynchronously, between edges) -> all outputs 0 immediately; no done after release.
- Early exit, both modes, a=0x8000_0000, b=0x0000_0001:
  - unsigned -> greater=1, done 2 cycles after accept, busy high for exactly 1 cycle;
  - signed -> less=1 with the same timing.
- Full scan equal: a=b=0x1234_5678 -> busy for 8 cycles, done 9 cycles after accept, equal=1.
- Full scan, LSB slice differs: a=0xFFFF_FFF5, b=0xFFFF_FFF6 unsigned -> less=1 at cycle 9; signed (-11 vs -10) -> less=1 at cycle 9.
- Handshake, start while busy: during an op (a=5, b=3) pulse start with a=1, b=9 -> first result greater=1 is reported and the second start is ignored.
- Handshake, start on done: assert start on the done cycle with a=1, b=9 -> accepted; busy the next cycle; flags cleared to 0; then less=1.
- Flush mid-compare: a=b=0x0F0F_0F0F, assert flush with start=1 at the 4th compare cycle -> IDLE next cycle, flags 0, no done; the following start behaves normally.
